// File: rtl/lcd1602_pkg.sv
`timescale 1ns/1ps
// Shared constants, FSM encodings and glyph ROM for the 16x2 LCD controller.
package lcd1602_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // address increment, no shift
    localparam logic [7:0] ADDR_LINE1   = 8'h80;
    localparam logic [7:0] ADDR_LINE2   = 8'hC0;

    typedef enum logic [2:0] {
        ST_CONFIG,
        ST_LINE1_ADDR,
        ST_LINE1_CHARS,
        ST_LINE2_ADDR,
        ST_LINE2_CHARS
    } state_t;

    // Three ticks per byte: present rs/data, raise E, drop E with data held.
    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } phase_t;

    // Configuration byte sent at position i of the power-up sequence.
    function automatic logic [7:0] cfg_cmd(input logic [3:0] i);
        case (i)
            4'd0:    return CMD_FUNC_SET;
            4'd1:    return CMD_DISP_ON;
            4'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY;
        endcase
    endfunction

    // Character pos (0..4) of the emoticon for face idx; unknown faces show "(?_?)".
    function automatic logic [7:0] face_glyph(input logic [7:0] idx,
                                              input logic [7:0] num_faces,
                                              input logic [2:0] pos);
        logic [39:0] s;
        s = "(?_?)";
        if (idx < num_faces) begin
            case (idx)
                8'd0:    s = "(^_^)";
                8'd1:    s = "(-_-)";
                8'd2:    s = "(o_o)";
                8'd3:    s = "(T_T)";
                8'd4:    s = "(>_<)";
                8'd5:    s = "(*_*)";
                8'd6:    s = "(u_u)";
                8'd7:    s = "(@_@)";
                8'd8:    s = "(x_x)";
                default: s = "(?_?)";
            endcase
        end
        case (pos)
            3'd0:    return s[39:32];
            3'd1:    return s[31:24];
            3'd2:    return s[23:16];
            3'd3:    return s[15:8];
            default: return s[7:0];
        endcase
    endfunction

endpackage

// File: rtl/lcd1602_tick_gen.sv
`timescale 1ns/1ps
// Divides clk by COUNT_MAX into a one-cycle tick pacing every LCD bus step.
module lcd1602_tick_gen #(
    parameter int COUNT_MAX = 8
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(COUNT_MAX - 1));

    // Free-running 0..COUNT_MAX-1 counter, wrapping on the tick cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/lcd1602_controller.sv
`timescale 1ns/1ps
// HD44780 16x2 write-only driver: one-shot config, then endless two-line refresh
// of the pet status (line 1) and face emoticon (line 2).
module lcd1602_controller
    import lcd1602_pkg::*;
#(
    parameter int MAX_VALUE           = 5,
    parameter int num_config_commands = 4,
    parameter int NUM_FACES           = 9,
    parameter int COUNT_MAX           = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(NUM_FACES)-1:0] face,
    input  logic [$clog2(MAX_VALUE):0]   feed_value,
    input  logic [$clog2(MAX_VALUE):0]   joy_value,
    input  logic [$clog2(MAX_VALUE):0]   energy_value,
    output logic                         rs,
    output logic                         rw,
    output logic                         enable,
    output logic [7:0]                   data
);
    localparam int FW = $clog2(NUM_FACES);
    localparam int VW = $clog2(MAX_VALUE) + 1;

    logic          tick;
    state_t        state, state_n;
    phase_t        phase, phase_n;
    logic [3:0]    idx, idx_n;
    logic          rs_n, en_n;
    logic [7:0]    data_n;
    logic          snap;
    logic          sel_rs;
    logic [7:0]    sel_data;
    logic [FW-1:0] s_face;
    logic [VW-1:0] s_feed, s_joy, s_energy;

    lcd1602_tick_gen #(.COUNT_MAX(COUNT_MAX)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign rw = 1'b0;

    function automatic logic [7:0] digit(input logic [VW-1:0] v);
        if (v > VW'(MAX_VALUE)) return 8'h30 + 8'(MAX_VALUE);
        return 8'h30 + 8'(v);
    endfunction

    // Byte owed for the current state/index, taken from the frame snapshot.
    always_comb begin
        sel_rs   = 1'b0;
        sel_data = 8'h00;
        case (state)
            ST_CONFIG:     sel_data = cfg_cmd(idx);
            ST_LINE1_ADDR: sel_data = ADDR_LINE1;
            ST_LINE2_ADDR: sel_data = ADDR_LINE2;
            ST_LINE1_CHARS: begin
                sel_rs = 1'b1;
                case (idx)
                    4'd0:       sel_data = "F";
                    4'd4:       sel_data = "J";
                    4'd8:       sel_data = "E";
                    4'd1, 4'd5,
                    4'd9:       sel_data = ":";
                    4'd2:       sel_data = digit(s_feed);
                    4'd6:       sel_data = digit(s_joy);
                    4'd10:      sel_data = digit(s_energy);
                    default:    sel_data = " ";
                endcase
            end
            ST_LINE2_CHARS: begin
                sel_rs = 1'b1;
                case (idx)
                    4'd0:    sel_data = "F";
                    4'd1:    sel_data = "A";
                    4'd2:    sel_data = "C";
                    4'd3:    sel_data = "E";
                    4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
                             sel_data = face_glyph(8'(s_face), 8'(NUM_FACES), 3'(idx - 4'd5));
                    default: sel_data = " ";
                endcase
            end
            default: ;
        endcase
    end

    // Next-state: step the byte phase on each tick, advance state after HOLD.
    always_comb begin
        state_n = state;
        phase_n = phase;
        idx_n   = idx;
        rs_n    = rs;
        data_n  = data;
        en_n    = enable;
        snap    = 1'b0;
        if (tick) begin
            case (phase)
                PH_SETUP: begin
                    rs_n    = sel_rs;
                    data_n  = sel_data;
                    en_n    = 1'b0;
                    phase_n = PH_PULSE;
                end
                PH_PULSE: begin
                    en_n    = 1'b1;
                    phase_n = PH_HOLD;
                end
                default: begin
                    en_n    = 1'b0;
                    phase_n = PH_SETUP;
                    idx_n   = 4'd0;
                    case (state)
                        ST_CONFIG:
                            if (idx == 4'(num_config_commands - 1)) begin
                                state_n = ST_LINE1_ADDR;
                                snap    = 1'b1;
                            end else idx_n = idx + 4'd1;
                        ST_LINE1_ADDR: state_n = ST_LINE1_CHARS;
                        ST_LINE1_CHARS:
                            if (idx == 4'd15) state_n = ST_LINE2_ADDR;
                            else              idx_n   = idx + 4'd1;
                        ST_LINE2_ADDR: state_n = ST_LINE2_CHARS;
                        default:
                            if (idx == 4'd15) begin
                                state_n = ST_LINE1_ADDR;
                                snap    = 1'b1;
                            end else idx_n = idx + 4'd1;
                    endcase
                end
            endcase
        end
    end

    // FSM and LCD pin registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_CONFIG;
            phase  <= PH_SETUP;
            idx    <= 4'd0;
            rs     <= 1'b0;
            enable <= 1'b0;
            data   <= 8'h00;
        end else begin
            state  <= state_n;
            phase  <= phase_n;
            idx    <= idx_n;
            rs     <= rs_n;
            enable <= en_n;
            data   <= data_n;
        end
    end

    // Inputs are frozen on entry to LINE1_ADDR so one frame never mixes values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_face   <= '0;
            s_feed   <= '0;
            s_joy    <= '0;
            s_energy <= '0;
        end else if (snap) begin
            s_face   <= face;
            s_feed   <= feed_value;
            s_joy    <= joy_value;
            s_energy <= energy_value;
        end
    end
endmodule

// File: tb/tb_lcd1602_controller.sv
`timescale 1ns/1ps
module tb_lcd1602_controller;
    logic       clk = 1'b0, reset = 1'b0;
    logic [3:0] face = 0, feed_value = 0, joy_value = 0, energy_value = 0;
    logic       rs, rw, enable;
    logic [7:0] data;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    lcd1602_controller dut (
        .clk(clk), .reset(reset), .face(face), .feed_value(feed_value),
        .joy_value(joy_value), .energy_value(energy_value),
        .rs(rs), .rw(rw), .enable(enable), .data(data));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic string emot(input int i);
        case (i)
            0: return "(^_^)"; 1: return "(-_-)"; 2: return "(o_o)";
            3: return "(T_T)"; 4: return "(>_<)"; 5: return "(*_*)";
            6: return "(u_u)"; 7: return "(@_@)"; 8: return "(x_x)";
            default: return "(?_?)";
        endcase
    endfunction
    function automatic int clampv(input int v); return (v > 5) ? 5 : v; endfunction
    function automatic string line1_str(input int f, input int j, input int e);
        return $sformatf("F:%0d J:%0d E:%0d     ", clampv(f), clampv(j), clampv(e));
    endfunction
    function automatic string line2_str(input int fc);
        return {"FACE ", emot(fc), "      "};
    endfunction

    // n = rising edges since reset release; frame f snapshots at edge 96+816*f.
    int n = 0;
    int sfeed[256], sjoy[256], sen[256], sface[256];
    always @(posedge clk or negedge reset) begin
        if (!reset) n <= 0;
        else begin
            n <= n + 1;
            if (n + 1 >= 96 && (n + 1 - 96) % 816 == 0 && (n + 1 - 96) / 816 < 256) begin
                sfeed[(n + 1 - 96) / 816] <= feed_value;
                sjoy [(n + 1 - 96) / 816] <= joy_value;
                sen  [(n + 1 - 96) / 816] <= energy_value;
                sface[(n + 1 - 96) / 816] <= face;
            end
        end
    end

    // {rs,data} of byte b in the output stream since reset.
    function automatic logic [8:0] exp_byte(input int b);
        int k, f;
        string s;
        case (b)
            0: return 9'h038; 1: return 9'h00C; 2: return 9'h001; 3: return 9'h006;
            default: ;
        endcase
        k = (b - 4) % 34;
        f = (b - 4) / 34;
        if (f > 255) return 9'h000;
        if (k == 0)  return 9'h080;
        if (k == 17) return 9'h0C0;
        if (k <= 16) begin
            s = line1_str(sfeed[f], sjoy[f], sen[f]);
            return {1'b1, s[k-1]};
        end
        s = line2_str(sface[f]);
        return {1'b1, s[k-18]};
    endfunction

    // Cycle-by-cycle compare of all LCD pins against the model.
    always @(negedge clk) begin
        logic [8:0] eb;
        logic       een;
        int         t;
        t = n / 8;
        if (!reset || t == 0) begin
            eb  = 9'h000;
            een = 1'b0;
        end else begin
            eb  = exp_byte((t - 1) / 3);
            een = ((t - 1) % 3 == 1);
        end
        check("cycle{rw,rs,en,data}", {21'd0, rw, rs, enable, data}, {21'd0, 1'b0, eb[8], een, eb[7:0]});
    end

    // Capture {rs,data} on every E rising edge.
    logic       prev_en = 1'b0;
    logic [8:0] cap[$];
    always @(negedge clk) begin
        if (enable && !prev_en) cap.push_back({rs, data});
        prev_en <= enable;
    end

    task automatic wait_cap(input int k);
        int c = 0;
        while (cap.size() < k && c < 5000) begin @(negedge clk); c++; end
        tests++;
        if (cap.size() < k) begin
            fails++;
            $display("FAIL wait_cap: got %0d bytes need %0d", cap.size(), k);
        end
    endtask

    task automatic check_cfg(input string tag);
        check({tag, "_cfg0"}, cap[0], 9'h038);
        check({tag, "_cfg1"}, cap[1], 9'h00C);
        check({tag, "_cfg2"}, cap[2], 9'h001);
        check({tag, "_cfg3"}, cap[3], 9'h006);
        check({tag, "_addr1"}, cap[4], 9'h080);
    endtask

    // Capture the next complete frame starting at a line-1 address byte.
    task automatic grab_frame(output string l1, output string l2);
        int  i0 = 0;
        bit  found = 0;
        l1 = ""; l2 = "";
        cap.delete();
        for (int c = 0; c < 3000 && !found; c++) begin
            @(negedge clk);
            for (int i = 0; i + 34 <= cap.size(); i++)
                if (!found && cap[i] == 9'h080) begin found = 1; i0 = i; end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL grab_frame: no complete frame, %0d bytes seen", cap.size());
        end else begin
            tests--;
            for (int j = 1; j <= 16; j++) l1 = $sformatf("%s%c", l1, cap[i0+j][7:0]);
            for (int j = 18; j <= 33; j++) l2 = $sformatf("%s%c", l2, cap[i0+j][7:0]);
            check("line2_addr", cap[i0+17], 9'h0C0);
        end
    endtask

    string l1, l2;
    initial begin
        // reset state
        repeat (3) begin
            @(negedge clk);
            check("reset_pins", {rw, rs, enable, data}, 11'h000);
        end
        @(negedge clk); #1 reset = 1'b1;
        repeat (8) @(negedge clk);
        check("clk8_data", data, 8'h38);
        check("clk8_en", enable, 1'b0);
        repeat (8) @(negedge clk);
        check("clk16_en", enable, 1'b1);
        repeat (8) @(negedge clk);
        check("clk24_en", enable, 1'b0);

        // configuration order
        wait_cap(5);
        check_cfg("boot");

        // default frame
        grab_frame(l1, l2);
        check_str("default_l1", l1, "F:0 J:0 E:0     ");
        check_str("default_l2", l2, "FACE (^_^)      ");

        // value update
        while ($time < 60000) @(negedge clk);
        #1 face = 3; feed_value = 2; joy_value = 4; energy_value = 1;
        grab_frame(l1, l2);
        grab_frame(l1, l2);
        check_str("update_l1", l1, "F:2 J:4 E:1     ");
        check_str("update_l2", l2, "FACE (T_T)      ");

        // mid-frame change leaves the current frame intact
        begin
            int c = 0;
            while (!(enable && !rs && data == 8'h80) && c < 2000) begin @(negedge clk); c++; end
            check("found_addr1", {enable, rs, data}, {1'b1, 1'b0, 8'h80});
        end
        repeat (2) @(negedge clk);
        cap.delete();
        repeat (100) @(negedge clk);
        #1 feed_value = 5; joy_value = 3; energy_value = 2;
        wait_cap(16);
        l1 = "";
        for (int j = 0; j < 16; j++) l1 = $sformatf("%s%c", l1, cap[j][7:0]);
        check_str("midframe_old_l1", l1, "F:2 J:4 E:1     ");
        grab_frame(l1, l2);
        check_str("midframe_new_l1", l1, "F:5 J:3 E:2     ");

        // clamping and out-of-range face
        @(negedge clk); #1 feed_value = 7; joy_value = 9; energy_value = 15; face = 12;
        grab_frame(l1, l2);
        grab_frame(l1, l2);
        check_str("clamp_l1", l1, "F:5 J:5 E:5     ");
        check_str("clamp_l2", l2, "FACE (?_?)      ");

        // randomized inputs at random moments; the per-cycle compare checks them
        repeat (8) begin
            repeat ($urandom_range(50, 900)) @(negedge clk);
            #1 face = 4'($urandom_range(0, 15)); feed_value = 4'($urandom_range(0, 15));
            joy_value = 4'($urandom_range(0, 15)); energy_value = 4'($urandom_range(0, 15));
        end
        grab_frame(l1, l2);
        grab_frame(l1, l2);
        check_str("random_l1", l1, line1_str(feed_value, joy_value, energy_value));
        check_str("random_l2", l2, line2_str(face));

        // reset asserted while E is high
        begin
            int c = 0;
            @(negedge clk);
            while (!enable && c < 200) begin @(negedge clk); c++; end
            check("found_pulse", enable, 1'b1);
        end
        #1 reset = 1'b0;
        #1 check("midreset_pins", {rs, enable, data}, 10'h000);
        cap.delete();
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        wait_cap(5);
        check_cfg("rereset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
